// File: rtl/pixel_readout_buffer.sv
// Captures sensor readout samples, tags row and end-of-window, queues them for a valid/ready consumer. Optional parity: PIXEL_READOUT_PARITY_EN.
// Latency: a sample is held in staging until the next capture or the read fall, then it is visible at the head 1 cycle after commit.
// Backpressure: m_ready low lets the FIFO fill; a commit into a full FIFO with no pop is dropped, which sets the sticky overflow flag and counts the drop.
module pixel_readout_buffer #(
  parameter int DATA_W = 8,
  parameter int ROW_W  = 1,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     read,
  input  logic [ROW_W-1:0]         row_pointer,
  input  logic [DATA_W-1:0]        out_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [DATA_W-1:0]        m_data,
  output logic [ROW_W-1:0]         m_row,
  output logic                     m_last,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  input  logic                     clear_overflow,
  output logic [CNT_W-1:0]         frame_count,
  output logic [CNT_W-1:0]         drop_count
`ifdef PIXEL_READOUT_PARITY_EN
  ,
  output logic                     m_parity,
  output logic                     parity_err_inject
`endif
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
`ifdef PIXEL_READOUT_PARITY_EN
    logic              par;
`endif
    logic              last;
    logic [ROW_W-1:0]  row;
    logic [DATA_W-1:0] data;
  } entry_t;

  typedef enum logic {IDLE, WINDOW} state_t;

  state_t            state_q, state_d;
  logic              read_d;
  logic [ROW_W-1:0]  row_d;
  logic              skip_win;
  logic [ROW_W-1:0]  stage_row;
  logic [DATA_W-1:0] stage_data;
  logic              stage_valid;
  logic              cap, fall;
  logic              commit_vld, commit_last, frame_done;
  entry_t            commit_dat, head_q;
  entry_t            mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [AW:0]       count, count_after_pop, count_nxt;
  logic              pop, full, wr_ok, drop;

  // A window already open when reset releases is skipped until read drops.
  assign stage_valid = (state_q == WINDOW);
  assign cap  = read & ~skip_win & (~read_d | (row_pointer != row_d));
  assign fall = ~read & read_d;

  // Edge detection copies of the sensor inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      read_d   <= 1'b1;
      row_d    <= '0;
      skip_win <= 1'b1;
    end else begin
      read_d <= read;
      row_d  <= row_pointer;
      if (!read) skip_win <= 1'b0;
    end
  end

  // Frame tracker state and staging register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      stage_row  <= '0;
      stage_data <= '0;
    end else begin
      state_q <= state_d;
      if (cap) begin
        stage_row  <= row_pointer;
        stage_data <= out_data;
      end
    end
  end

  // Next state and commit decision: a new capture pushes the old stage out, the read fall closes the window.
  always_comb begin
    state_d     = state_q;
    commit_vld  = 1'b0;
    commit_last = 1'b0;
    frame_done  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cap) state_d = WINDOW;
      end
      WINDOW: begin
        if (cap) begin
          commit_vld = 1'b1;
        end else if (fall) begin
          commit_vld  = 1'b1;
          commit_last = 1'b1;
          frame_done  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Entry written to the FIFO on commit.
  always_comb begin
    commit_dat      = '0;
    commit_dat.data = stage_data;
    commit_dat.row  = stage_row;
    commit_dat.last = commit_last;
`ifdef PIXEL_READOUT_PARITY_EN
    commit_dat.par  = ^{stage_row, stage_data};
`endif
  end

  assign m_valid         = (count != '0);
  assign pop             = m_valid & m_ready;
  assign full            = (count == (AW+1)'(DEPTH));
  assign wr_ok           = commit_vld & (~full | pop);
  assign drop            = commit_vld & full & ~pop;
  assign rd_ptr_nxt      = rd_ptr + AW'(pop);
  assign count_after_pop = count - (AW+1)'(pop);
  assign count_nxt       = count_after_pop + (AW+1)'(wr_ok);

  // Storage array; contents need no reset since occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= commit_dat;
  end

  // Pointers, occupancy and registered head; the head holds its value when the FIFO drains.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head_q <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= rd_ptr_nxt;
      count  <= count_nxt;
      if (count_nxt != '0)
        head_q <= (count_after_pop == '0) ? commit_dat : mem[rd_ptr_nxt];
    end
  end

  // Frame and drop counters; a new drop beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_count <= '0;
      drop_count  <= '0;
      overflow    <= 1'b0;
    end else begin
      if (frame_done) frame_count <= frame_count + CNT_W'(1);
      if (drop) begin
        overflow <= 1'b1;
        if (clear_overflow)   drop_count <= CNT_W'(1);
        else if (!(&drop_count)) drop_count <= drop_count + CNT_W'(1);
      end else if (clear_overflow) begin
        overflow   <= 1'b0;
        drop_count <= '0;
      end
    end
  end

  assign m_data = head_q.data;
  assign m_row  = head_q.row;
  assign m_last = head_q.last;
  assign level  = count;
`ifdef PIXEL_READOUT_PARITY_EN
  assign m_parity          = head_q.par;
  assign parity_err_inject = 1'b0;
`endif

endmodule
